// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory req/gnt/rvalid interface
interface if_stage_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   req;
  logic [ADDR_WIDTH-1:0]  addr;
  logic                   gnt;
  logic                   rvalid;
  logic [INSTR_WIDTH-1:0] rdata;

  // Fetch stage issues requests; the memory grants and responds.
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I instruction fetch stage with IF/ID register
module if_stage #(
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_stall,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  if_stage_if.master             imem,
  output logic [INSTR_WIDTH-1:0] o_IF_instruction,
  output logic [ADDR_WIDTH-1:0]  o_IF_pc,
  output logic                   o_IF_valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   squash;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [ADDR_WIDTH-1:0]  skid_pc;

  logic [ADDR_WIDTH-1:0]  redirect_target;
  logic                   unused_redirect_lsbs;

  // Targets are word aligned; the low two bits of the redirect address carry no meaning.
  assign redirect_target      = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = &{1'b0, i_redirect_pc[1:0]};

  // The request is suppressed while reset is asserted so nothing is issued during the reset cycle.
  assign imem.req  = (state == S_REQ) && i_reset_n;
  assign imem.addr = pc;

  // Fetch FSM, PC, squash flag, skid buffer and IF/ID register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state            <= S_REQ;
      pc               <= RESET_PC;
      squash           <= 1'b0;
      skid_instr       <= NOP_INSTR;
      skid_pc          <= RESET_PC;
      o_IF_valid       <= 1'b0;
      o_IF_instruction <= NOP_INSTR;
      o_IF_pc          <= RESET_PC;
    end else if (i_redirect) begin
      // Redirect wins over stall: flush IF/ID and the skid, restart at the target.
      pc               <= redirect_target;
      o_IF_valid       <= 1'b0;
      o_IF_instruction <= NOP_INSTR;
      case (state)
        S_REQ: begin
          // A grant in this cycle leaves a stale request in flight; its data must be dropped.
          if (imem.gnt) begin
            state  <= S_WAIT;
            squash <= 1'b1;
          end else begin
            state  <= S_REQ;
          end
        end
        S_WAIT: begin
          if (imem.rvalid) begin
            state  <= S_REQ;
            squash <= 1'b0;
          end else begin
            state  <= S_WAIT;
            squash <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase
    end else begin
      // Decode consumed the IF/ID contents; bubble unless something new lands below.
      if (!i_stall) begin
        o_IF_valid       <= 1'b0;
        o_IF_instruction <= NOP_INSTR;
      end
      case (state)
        S_REQ: begin
          if (imem.gnt) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.rvalid) begin
            if (squash) begin
              squash <= 1'b0;
              state  <= S_REQ;
            end else if (!i_stall) begin
              o_IF_valid       <= 1'b1;
              o_IF_instruction <= imem.rdata;
              o_IF_pc          <= pc;
              pc               <= pc + PC_STEP;
              state            <= S_REQ;
            end else begin
              skid_instr <= imem.rdata;
              skid_pc    <= pc;
              pc         <= pc + PC_STEP;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            o_IF_valid       <= 1'b1;
            o_IF_instruction <= skid_instr;
            o_IF_pc          <= skid_pc;
            state            <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;

  if_stage_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) imem ();

  if_stage #(
    .INSTR_WIDTH(32),
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .NOP_INSTR  (NOP)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_stall         (stall),
    .i_redirect      (redirect),
    .i_redirect_pc   (redirect_pc),
    .imem            (imem),
    .o_IF_instruction(if_instr),
    .o_IF_pc         (if_pc),
    .o_IF_valid      (if_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [17];

  // Reference model state: outstanding request, squash, skid queue, IF/ID contents.
  logic [31:0] m_pc;
  logic        m_out;
  logic        m_squash;
  logic [63:0] m_skid [$];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ifpc;
  logic        mem_pend;

  task automatic drive(input logic rst, input logic st, input logic rd, input logic [31:0] rpc,
                       input logic g, input logic rv, input logic [31:0] rdat);
    reset_n     = rst;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem.gnt    = g;
    imem.rvalid = rv;
    imem.rdata  = rdat;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ereq, input logic [31:0] eaddr,
                       input logic evalid, input logic [31:0] einstr, input logic [31:0] epc);
    n_checks++;
    if (imem.req !== ereq || imem.addr !== eaddr || if_valid !== evalid ||
        if_instr !== einstr || if_pc !== epc) begin
      n_fail++;
      $display("FAIL %s: got req=%0b addr=%h valid=%0b instr=%h pc=%h, want req=%0b addr=%h valid=%0b instr=%h pc=%h",
               name, imem.req, imem.addr, if_valid, if_instr, if_pc, ereq, eaddr, evalid, einstr, epc);
    end
  endtask

  task automatic model_step(input logic rst, input logic st, input logic rd, input logic [31:0] rpc,
                            input logic g, input logic rv, input logic [31:0] rdat);
    logic        was_idle;
    logic [63:0] e;
    if (!rst) begin
      m_pc = 32'h0; m_out = 1'b0; m_squash = 1'b0; m_skid.delete();
      m_valid = 1'b0; m_instr = NOP; m_ifpc = 32'h0;
    end else if (rd) begin
      was_idle = !m_out && (m_skid.size() == 0);
      m_pc = rpc & 32'hFFFF_FFFC;
      m_valid = 1'b0; m_instr = NOP;
      m_skid.delete();
      if (was_idle) begin
        m_out = g; m_squash = g;
      end else if (m_out) begin
        if (rv) begin m_out = 1'b0; m_squash = 1'b0; end
        else m_squash = 1'b1;
      end
    end else begin
      if (!st) begin m_valid = 1'b0; m_instr = NOP; end
      if (m_skid.size() != 0) begin
        if (!st) begin
          e = m_skid.pop_front();
          m_valid = 1'b1; m_instr = e[63:32]; m_ifpc = e[31:0];
        end
      end else if (m_out) begin
        if (rv) begin
          m_out = 1'b0;
          if (m_squash) m_squash = 1'b0;
          else begin
            if (!st) begin m_valid = 1'b1; m_instr = rdat; m_ifpc = m_pc; end
            else m_skid.push_back({rdat, m_pc});
            m_pc = m_pc + 32'd4;
          end
        end
      end else if (g) begin
        m_out = 1'b1;
      end
    end
  endtask

  initial begin
    logic        r_rst, r_stall, r_redir, r_gnt, r_rv, req_now;
    logic [31:0] r_rpc, r_rdata;

    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;

    //        rst stall redir rpc          gnt rv  rdata          req addr         valid instr          pc
    tbl[0]  = '{L, L, L, 32'h0,   L, L, 32'h0,         L, 32'h000, L, NOP,           32'h000};
    tbl[1]  = '{H, L, L, 32'h0,   H, L, 32'h0,         L, 32'h000, L, NOP,           32'h000};
    tbl[2]  = '{H, L, L, 32'h0,   L, H, 32'h00500093,  H, 32'h004, H, 32'h00500093,  32'h000};
    tbl[3]  = '{H, L, L, 32'h0,   H, L, 32'h0,         L, 32'h004, L, NOP,           32'h000};
    tbl[4]  = '{H, L, L, 32'h0,   L, H, 32'h00A00113,  H, 32'h008, H, 32'h00A00113,  32'h004};
    tbl[5]  = '{H, L, L, 32'h0,   H, L, 32'h0,         L, 32'h008, L, NOP,           32'h004};
    tbl[6]  = '{H, H, L, 32'h0,   L, H, 32'h002081B3,  L, 32'h00C, L, NOP,           32'h004};
    tbl[7]  = '{H, H, L, 32'h0,   L, L, 32'h0,         L, 32'h00C, L, NOP,           32'h004};
    tbl[8]  = '{H, H, L, 32'h0,   L, L, 32'h0,         L, 32'h00C, L, NOP,           32'h004};
    tbl[9]  = '{H, L, L, 32'h0,   L, L, 32'h0,         H, 32'h00C, H, 32'h002081B3,  32'h008};
    tbl[10] = '{H, L, L, 32'h0,   H, L, 32'h0,         L, 32'h00C, L, NOP,           32'h008};
    tbl[11] = '{H, L, L, 32'h0,   L, H, 32'h40000033,  H, 32'h010, H, 32'h40000033,  32'h00C};
    tbl[12] = '{H, L, L, 32'h0,   H, L, 32'h0,         L, 32'h010, L, NOP,           32'h00C};
    tbl[13] = '{H, L, H, 32'h100, L, L, 32'h0,         L, 32'h100, L, NOP,           32'h00C};
    tbl[14] = '{H, L, L, 32'h0,   L, H, 32'hDEADBEEF,  H, 32'h100, L, NOP,           32'h00C};
    tbl[15] = '{H, L, L, 32'h0,   H, L, 32'h0,         L, 32'h100, L, NOP,           32'h00C};
    tbl[16] = '{H, L, L, 32'h0,   L, H, 32'h00100093,  H, 32'h104, H, 32'h00100093,  32'h100};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst_n, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata);
      check($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].instr, tbl[i].pc);
    end

    // Redirect coincident with rvalid: data dropped, no squash left behind.
    drive(H, L, L, 32'h0,   H, L, 32'h0);
    check("a_gnt", L, 32'h104, L, NOP, 32'h100);
    drive(H, L, H, 32'h202, L, H, 32'h11111111);
    check("redir_with_rvalid", H, 32'h200, L, NOP, 32'h100);
    drive(H, L, L, 32'h0,   H, L, 32'h0);
    check("a_gnt2", L, 32'h200, L, NOP, 32'h100);
    drive(H, L, L, 32'h0,   L, H, 32'h22222293);
    check("no_stale_squash", H, 32'h204, H, 32'h22222293, 32'h200);

    // Redirect during HOLD under stall: skid flushed.
    drive(H, L, L, 32'h0,   H, L, 32'h0);
    check("b_gnt", L, 32'h204, L, NOP, 32'h200);
    drive(H, H, L, 32'h0,   L, H, 32'h55555555);
    check("hold_enter", L, 32'h208, L, NOP, 32'h200);
    drive(H, H, H, 32'h300, L, L, 32'h0);
    check("redir_in_hold", H, 32'h300, L, NOP, 32'h200);
    drive(H, L, L, 32'h0,   L, L, 32'h0);
    check("skid_flushed", H, 32'h300, L, NOP, 32'h200);

    // Redirect with a grant in REQ: old request is squashed.
    drive(H, L, H, 32'h400, H, L, 32'h0);
    check("redir_with_gnt", L, 32'h400, L, NOP, 32'h200);
    drive(H, L, L, 32'h0,   L, H, 32'h66666666);
    check("squashed_resp", H, 32'h400, L, NOP, 32'h200);

    // Reset during WAIT, then a stray response.
    drive(H, L, L, 32'h0,   H, L, 32'h0);
    check("c_gnt", L, 32'h400, L, NOP, 32'h200);
    drive(L, L, L, 32'h0,   L, L, 32'h0);
    check("mid_reset", L, 32'h000, L, NOP, 32'h000);
    drive(H, L, L, 32'h0,   L, H, 32'h33333333);
    check("stray_rvalid", H, 32'h000, L, NOP, 32'h000);
    drive(H, L, L, 32'h0,   H, L, 32'h0);
    check("c_gnt2", L, 32'h000, L, NOP, 32'h000);
    drive(H, L, L, 32'h0,   L, H, 32'h00500093);
    check("after_reset_fetch", H, 32'h004, H, 32'h00500093, 32'h000);

    // Randomized traffic against the reference model.
    mem_pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r_rst   = (i != 0) && ($urandom_range(0, 199) != 0);
      r_stall = ($urandom_range(0, 2) == 0);
      r_redir = ($urandom_range(0, 9) == 0);
      r_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      req_now = r_rst && !m_out && (m_skid.size() == 0);
      r_gnt   = !mem_pend && ($urandom_range(0, 2) != 0);
      r_rv    = mem_pend && ($urandom_range(0, 1) == 1);
      r_rdata = $urandom;
      if (i == 0) begin
        m_out = 1'b0; m_skid.delete();
      end
      model_step(r_rst, r_stall, r_redir, r_rpc, r_gnt, r_rv, r_rdata);
      if (r_rv) mem_pend = 1'b0;
      if (req_now && r_gnt) mem_pend = 1'b1;
      drive(r_rst, r_stall, r_redir, r_rpc, r_gnt, r_rv, r_rdata);
      check($sformatf("rand%0d", i), r_rst && !m_out && (m_skid.size() == 0), m_pc, m_valid, m_instr, m_ifpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
